// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter (5-9 data bits, parity, 1/1.5/2 stop, break)
module uart_tx_cfg #(
    parameter int DBIT_MAX = 9,
    parameter int OVS      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_tick,
    input  logic [DBIT_MAX-1:0] din,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [3:0]          cfg_dbits,
    input  logic [1:0]          cfg_parity,
    input  logic [1:0]          cfg_stop,
    input  logic                brk,
    output logic                tx_busy,
    output logic                tx_done_tick,
    output logic                tx
);
    localparam int SW = $clog2(2 * OVS);
    localparam logic [3:0]    DMAX      = 4'(DBIT_MAX);
    localparam logic [SW-1:0] S_BIT     = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP1   = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP15  = SW'(3 * OVS / 2 - 1);
    localparam logic [SW-1:0] S_STOP2   = SW'(2 * OVS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t              state;
    logic [SW-1:0]       s;
    logic [3:0]          n;
    logic [3:0]          dbits;
    logic [DBIT_MAX-1:0] shift;
    logic                par_en;
    logic                par_bit;
    logic [1:0]          stop_sel;

    logic [3:0]          dbits_clamp;
    logic [DBIT_MAX-1:0] mask;
    logic                par_calc;
    logic [SW-1:0]       stop_last;

    always_comb begin
        if (cfg_dbits < 4'd5)
            dbits_clamp = 4'd5;
        else if (cfg_dbits > DMAX)
            dbits_clamp = DMAX;
        else
            dbits_clamp = cfg_dbits;
        for (int i = 0; i < DBIT_MAX; i++)
            mask[i] = (i < int'(dbits_clamp));
        par_calc = ^(din & mask);
        case (stop_sel)
            2'b00:   stop_last = S_STOP1;
            2'b01:   stop_last = S_STOP15;
            default: stop_last = S_STOP2;
        endcase
    end

    assign tx_ready = (state == IDLE) && !brk;
    assign tx_busy  = (state != IDLE);

    // tx is computed from the current state, so the line trails each state change by one clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            dbits        <= '0;
            shift        <= '0;
            par_en       <= 1'b0;
            par_bit      <= 1'b0;
            stop_sel     <= 2'b00;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (brk) begin
                        state <= BREAK;
                    end else if (tx_valid) begin
                        shift    <= din;
                        dbits    <= dbits_clamp;
                        par_en   <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                        par_bit  <= (cfg_parity == 2'b10) ? ~par_calc : par_calc;
                        stop_sel <= cfg_stop;
                        s        <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (s_tick) begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            n     <= '0;
                            state <= DATA;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (s_tick) begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            shift <= shift >> 1;
                            if (n == dbits - 4'd1)
                                state <= par_en ? PARITY : STOP;
                            else
                                n <= n + 4'd1;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                PARITY: begin
                    tx <= par_bit;
                    if (s_tick) begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            state <= STOP;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (s_tick) begin
                        if (s == stop_last) begin
                            s            <= '0;
                            tx_done_tick <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                BREAK: begin
                    tx <= 1'b0;
                    // a break always ends with a single stop period, whatever the last frame used
                    if (!brk) begin
                        stop_sel <= 2'b00;
                        s        <= '0;
                        state    <= STOP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - scoreboard bench for uart_tx_cfg with a frame-level reference model
module tb_uart_tx_cfg;
    localparam int DBIT_MAX = 9;
    localparam int OVS      = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       s_tick = 1'b0;
    logic [8:0] din = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [3:0] cfg_dbits = 4'd8;
    logic [1:0] cfg_parity = 2'b00;
    logic [1:0] cfg_stop = 2'b00;
    logic       brk = 1'b0;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       tx;

    uart_tx_cfg #(.DBIT_MAX(DBIT_MAX), .OVS(OVS)) dut (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .din(din), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity),
        .cfg_stop(cfg_stop), .brk(brk), .tx_busy(tx_busy),
        .tx_done_tick(tx_done_tick), .tx(tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_break;
        int          nbits;
        logic [15:0] bits;
        int          total;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int exp_done = 0;
    int seen_done = 0;
    int mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic summary_and_finish();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT, expected progress", name);
        summary_and_finish();
    endtask

    // Whole-frame expectation: line value at the centre of every bit and ticks from accept to done.
    function automatic exp_t model_frame(input logic [8:0] d, input logic [3:0] db,
                                         input logic [1:0] par, input logic [1:0] stp);
        exp_t e;
        int   nb, ones, k, stop_t;
        nb = (db < 5) ? 5 : ((db > DBIT_MAX) ? DBIT_MAX : int'(db));
        e.is_break = 1'b0;
        e.bits = '0;
        e.bits[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < nb; i++) begin
            e.bits[1 + i] = d[i];
            ones += int'(d[i]);
        end
        k = 1 + nb;
        if (par == 2'b01) begin
            e.bits[k] = (ones % 2 == 1);
            k++;
        end else if (par == 2'b10) begin
            e.bits[k] = (ones % 2 == 0);
            k++;
        end
        e.bits[k] = 1'b1;
        k++;
        e.nbits = k;
        stop_t = (stp == 2'b00) ? OVS : ((stp == 2'b01) ? OVS * 3 / 2 : 2 * OVS);
        e.total = (k - 1) * OVS + stop_t;
        return e;
    endfunction

    initial begin
        int gap;
        gap = 2;
        forever begin
            @(posedge clk);
            #1;
            if (gap == 0) begin
                s_tick = 1'b1;
                gap = $urandom_range(1, 3);
            end else begin
                s_tick = 1'b0;
                gap--;
            end
        end
    end

    // Monitor: samples at negedge; s_tick seen here is the value the next rising edge will use.
    initial begin
        int   tcnt, bcyc, bcnt;
        bit   released, just_done;
        exp_t cur;
        tcnt = 0; bcyc = 0; bcnt = 0; released = 0;
        forever begin
            @(negedge clk);
            just_done = 0;
            if (!rst_n) begin
                mode = 0;
                continue;
            end
            if (mode == 1) begin
                if (tx_done_tick) begin
                    seen_done++;
                    check("frame_ticks", tcnt, cur.total);
                    mode = 0;
                    just_done = 1;
                end else begin
                    if (s_tick && (tcnt % OVS == OVS / 2) && (tcnt / OVS < cur.nbits))
                        check("frame_bit", {31'd0, tx}, {31'd0, cur.bits[tcnt / OVS]});
                    if (s_tick) tcnt++;
                    if (tcnt > cur.total + OVS) begin
                        check("frame_done_missing", tcnt, cur.total);
                        mode = 0;
                    end
                end
            end else if (mode == 2) begin
                if (tx_done_tick) begin
                    seen_done++;
                    check("break_stop_ticks", bcnt, OVS);
                    mode = 0;
                    just_done = 1;
                end else if (!released) begin
                    if (!brk) begin
                        released = 1;
                    end else begin
                        bcyc++;
                        if (bcyc >= 2) check("break_line", {31'd0, tx}, 32'd0);
                        check("break_ready", {31'd0, tx_ready}, 32'd0);
                    end
                end else begin
                    if (s_tick) begin
                        if (bcnt == OVS / 2) check("break_stop_line", {31'd0, tx}, 32'd1);
                        bcnt++;
                    end
                    if (bcnt > 2 * OVS) begin
                        check("break_done_missing", bcnt, OVS);
                        mode = 0;
                    end
                end
            end
            if (mode == 0) begin
                if (!just_done) begin
                    check("idle_no_done", {31'd0, tx_done_tick}, 32'd0);
                    check("idle_line", {31'd0, tx}, 32'd1);
                end
                if (brk && !tx_busy) begin
                    if (sb.size() == 0 || !sb[0].is_break) begin
                        check("unexpected_break", 32'd1, 32'd0);
                    end else begin
                        cur = sb.pop_front();
                        mode = 2; bcyc = 0; bcnt = 0; released = 0;
                    end
                end else if (tx_valid && tx_ready) begin
                    if (sb.size() == 0 || sb[0].is_break) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        cur = sb.pop_front();
                        mode = 1; tcnt = 0;
                    end
                end
            end
        end
    end

    task automatic wait_accept(output bit was_done);
        int cyc;
        cyc = 0;
        was_done = 0;
        forever begin
            @(negedge clk);
            if (tx_ready) begin
                was_done = tx_done_tick;
                @(posedge clk);
                #1;
                return;
            end
            cyc++;
            if (cyc > 20000) timeout("accept");
        end
    endtask

    task automatic send(input logic [8:0] d, input logic [3:0] db, input logic [1:0] par,
                        input logic [1:0] stp, input bit hold, output bit was_done);
        din = d; cfg_dbits = db; cfg_parity = par; cfg_stop = stp;
        tx_valid = 1'b1;
        sb.push_back(model_frame(d, db, par, stp));
        exp_done++;
        wait_accept(was_done);
        if (!hold) begin
            tx_valid = 1'b0;
            din = 9'($urandom);
            cfg_dbits = 4'($urandom);
            cfg_parity = 2'($urandom);
            cfg_stop = 2'($urandom);
        end
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) timeout("idle");
        end while (tx_busy || mode != 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit   wd;
        int   ticks;
        exp_t be;
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_done", {31'd0, tx_done_tick}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        send(9'h0A5, 4'd8, 2'b00, 2'b00, 1'b0, wd); wait_idle();
        send(9'h1B5, 4'd7, 2'b01, 2'b10, 1'b0, wd); wait_idle();
        send(9'h1FF, 4'd9, 2'b10, 2'b01, 1'b0, wd); wait_idle();
        send(9'h0D3, 4'd3, 2'b01, 2'b00, 1'b0, wd); wait_idle();
        send(9'h12C, 4'd12, 2'b10, 2'b11, 1'b0, wd); wait_idle();

        send(9'h011, 4'd8, 2'b00, 2'b00, 1'b1, wd);
        send(9'h022, 4'd8, 2'b00, 2'b00, 1'b1, wd);
        check("b2b_no_gap_2", {31'd0, wd}, 32'd1);
        send(9'h033, 4'd8, 2'b00, 2'b00, 1'b0, wd);
        check("b2b_no_gap_3", {31'd0, wd}, 32'd1);
        wait_idle();

        be.is_break = 1'b1; be.nbits = 0; be.bits = '0; be.total = OVS;
        sb.push_back(be);
        exp_done++;
        sb.push_back(model_frame(9'h05A, 4'd8, 2'b01, 2'b00));
        exp_done++;
        din = 9'h05A; cfg_dbits = 4'd8; cfg_parity = 2'b01; cfg_stop = 2'b00;
        tx_valid = 1'b1;
        brk = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("brk_ready_low", {31'd0, tx_ready}, 32'd0);
        check("brk_line_low", {31'd0, tx}, 32'd0);
        brk = 1'b0;
        wait_accept(wd);
        tx_valid = 1'b0;
        wait_idle();

        send(9'h0A5, 4'd8, 2'b00, 2'b00, 1'b0, wd);
        ticks = 0;
        while (ticks < 88) begin
            @(posedge clk);
            if (s_tick) ticks++;
        end
        #2;
        check("pre_rst_bit4", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_ready", {31'd0, tx_ready}, 32'd1);
        check("midrst_busy", {31'd0, tx_busy}, 32'd0);
        exp_done--;
        repeat (4) @(posedge clk);
        check("midrst_no_done", {31'd0, tx_done_tick}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(9'h0A5, 4'd8, 2'b00, 2'b00, 1'b0, wd); wait_idle();

        for (int i = 0; i < 24; i++) begin
            bit hold;
            hold = ($urandom_range(0, 2) == 0);
            send(9'($urandom), 4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), hold, wd);
            if (!hold) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat (5) @(posedge clk);
                    #1 brk = 1'b1;
                    repeat (10) @(posedge clk);
                    #1 brk = 1'b0;
                end
                if ($urandom_range(0, 1) == 1) begin
                    wait_idle();
                    repeat ($urandom_range(0, 20)) @(posedge clk);
                    #1;
                end
            end
        end
        tx_valid = 1'b0;
        wait_idle();
        check("sb_drained", sb.size(), 32'd0);
        check("done_count", seen_done, exp_done);
        summary_and_finish();
    end
endmodule
